// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the elastic pipeline stage registers of the 5-stage
// MIPS core: occupancy state encoding and per-boundary bundle widths.
// No ports (package).
// ---------------------------------------------------------------------------
package pipe_pkg;

   // Stage occupancy; the encoding equals the number of entries held.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   // Per-boundary bundle widths (data concatenated by the caller).
   localparam int unsigned IFID_DATA_W  = 64;   // PC+4, instruction
   localparam int unsigned IFID_CTRL_W  = 1;
   localparam int unsigned IDEX_DATA_W  = 143;  // PC+4, rs/rt values, imm, rs/rt/rd
   localparam int unsigned IDEX_CTRL_W  = 10;
   localparam int unsigned EXMEM_DATA_W = 69;   // ALU result, store data, dest reg
   localparam int unsigned EXMEM_CTRL_W = 5;
   localparam int unsigned MEMWB_DATA_W = 69;   // load data, ALU result, dest reg
   localparam int unsigned MEMWB_CTRL_W = 2;

endpackage

// File: rtl/pipe_slot.sv
// ---------------------------------------------------------------------------
// pipe_slot
// One storage entry of an elastic stage: data bundle, control bundle and a
// valid flag, with load and clear enables (clear wins over load).
// Ports:
//   clk, rst          clock (rising edge), async active-high reset
//   load              capture in_data/in_ctrl and set valid
//   clr               drop the entry: valid=0, ctrl=0, data=0 if CLR_DATA
//   in_data, in_ctrl  bundle to capture
//   out_valid         entry holds a bundle
//   out_data,out_ctrl stored bundle
// ---------------------------------------------------------------------------
module pipe_slot
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned CTRL_W   = 8,
   parameter int unsigned CLR_DATA = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              clr,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ctrl  <= '0;
      end else if (clr) begin
         out_valid <= 1'b0;
         out_ctrl  <= '0;
         if (CLR_DATA != 0) out_data <= '0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= in_data;
         out_ctrl  <= in_ctrl;
      end
   end

endmodule

// File: rtl/pipe_stage_elastic.sv
// ---------------------------------------------------------------------------
// pipe_stage_elastic
// Elastic pipeline stage register with valid/ready handshake, synchronous
// flush and an optional skid entry. Bubbles present all-zero control (NOP).
// Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   flush               synchronous kill of all held entries
//   in_valid/in_ready   upstream handshake
//   in_data/in_ctrl     upstream bundle
//   out_valid/out_ready downstream handshake
//   out_data/out_ctrl   bundle to next stage (ctrl forced 0 when !out_valid)
//   occupancy           entries held (0..2, 2 only with SKID=1)
// ---------------------------------------------------------------------------
module pipe_stage_elastic
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned CTRL_W   = 8,
   parameter int unsigned SKID     = 1,
   parameter int unsigned CLR_DATA = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        occupancy
);

   state_t            state, state_nxt;
   logic              rdy_q;
   logic              accept, drain;
   logic              main_load, main_clr;
   logic              main_valid, skid_valid;
   logic [DATA_W-1:0] main_data, skid_data, main_src_data;
   logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_src_ctrl;

   // rdy_q is constant 1 without a skid entry (state never reaches TWO),
   // so the single-entry variant reduces to the combinational term.
   assign in_ready = (SKID != 0) ? rdy_q : (rdy_q & (~main_valid | out_ready));

   assign accept = in_valid & in_ready & ~flush;
   assign drain  = main_valid & out_ready;

   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = ST_EMPTY;
      end else begin
         unique case (state)
            ST_EMPTY: if (accept) state_nxt = ST_ONE;
            ST_ONE: begin
               if (accept && !drain && (SKID != 0)) state_nxt = ST_TWO;
               else if (!accept && drain)           state_nxt = ST_EMPTY;
            end
            ST_TWO:   if (drain) state_nxt = ST_ONE;
            default:  state_nxt = ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_EMPTY;
         rdy_q <= 1'b1;
      end else begin
         state <= state_nxt;
         rdy_q <= (state_nxt != ST_TWO);
      end
   end

   assign occupancy = state;

   // Main refills from the skid entry when one is waiting, otherwise from
   // the input; this keeps main strictly older than skid.
   assign main_src_data = skid_valid ? skid_data : in_data;
   assign main_src_ctrl = skid_valid ? skid_ctrl : in_ctrl;
   assign main_load     = (accept & (~main_valid | drain)) | (skid_valid & drain);
   assign main_clr      = flush | (drain & ~accept & ~skid_valid);

   pipe_slot #(
      .DATA_W   (DATA_W),
      .CTRL_W   (CTRL_W),
      .CLR_DATA (CLR_DATA)
   ) u_main (
      .clk       (clk),
      .rst       (rst),
      .load      (main_load),
      .clr       (main_clr),
      .in_data   (main_src_data),
      .in_ctrl   (main_src_ctrl),
      .out_valid (main_valid),
      .out_data  (main_data),
      .out_ctrl  (main_ctrl)
   );

   generate
      if (SKID != 0) begin : g_skid
         logic skid_load, skid_clr;
         assign skid_load = accept & main_valid & ~drain;
         assign skid_clr  = flush | (skid_valid & drain);

         pipe_slot #(
            .DATA_W   (DATA_W),
            .CTRL_W   (CTRL_W),
            .CLR_DATA (CLR_DATA)
         ) u_skid (
            .clk       (clk),
            .rst       (rst),
            .load      (skid_load),
            .clr       (skid_clr),
            .in_data   (in_data),
            .in_ctrl   (in_ctrl),
            .out_valid (skid_valid),
            .out_data  (skid_data),
            .out_ctrl  (skid_ctrl)
         );
      end else begin : g_noskid
         assign skid_valid = 1'b0;
         assign skid_data  = '0;
         assign skid_ctrl  = '0;
      end
   endgenerate

   assign out_valid = main_valid;
   assign out_data  = main_data;
   assign out_ctrl  = main_valid ? main_ctrl : '0;

endmodule
